// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, {Cout,Sum} = a + b + cin.
// One full-adder cell (two half-adder stages) processes one bit per clock,
// LSB first. An operation takes WIDTH SHIFT cycles plus one DONE cycle.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered
// two's-complement overflow output ovf.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned       CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               load;
    logic               shift_en;
    logic               last_bit;

    logic               ha0_s;
    logic               ha0_c;
    logic               fa_s;
    logic               fa_c;

    // Full-adder cell as two cascaded half adders on the operand LSBs and carry FF
    always_comb begin
        ha0_s = a_sh[0] ^ b_sh[0];
        ha0_c = a_sh[0] & b_sh[0];
        fa_s  = ha0_s ^ carry;
        fa_c  = ha0_c | (ha0_s & carry);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
        end
    end

    // Operand shift registers: captured on accept, shifted right each SHIFT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
        end else if (shift_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
        end
    end

    // Carry flip-flop: seeded with cin, then follows the cell's carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= cin;
        end else if (shift_en) begin
            carry <= fa_c;
        end
    end

    // Bit counter over the WIDTH SHIFT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result shift register: sum bits enter at the MSB and move toward bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sh <= '0;
        end else if (load) begin
            res_sh <= '0;
        end else if (shift_en) begin
            res_sh <= {fa_s, res_sh[WIDTH-1:1]};
        end
    end

    // Visible result: updated only on entry to DONE, including the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else if (last_bit) begin
            Sum  <= {fa_s, res_sh[WIDTH-1:1]};
            Cout <= fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB (carry FF at the last bit) xor carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= carry ^ fa_c;
        end
    end
`endif

endmodule
